boot_loader: RTL and testbench
==============================

# boot_loader

Serial program loader that writes a boot image into `random_access_memory` through its `a`/`din`/`rw` port. It is the writer side of the instruction memory that `control_unit` fetches from. It holds the core in reset-hold while it takes a little-endian byte stream (word count, then data words) and writes each assembled word to consecutive RAM addresses. Once the image is in memory it releases the core. It sits between a byte source (UART receiver or bench) and the RAM write port.

## Interface
Parameters:
- `BASE_ADDR`, default 0: RAM word address of the first image word.
- `DEPTH`, default 8192: RAM size in words. Used for the bounds check.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `byte_data` input 8: incoming stream byte.
- `byte_valid` input 1: `byte_data` is valid.
- `byte_ready` output 1: loader accepts a byte this cycle.
- `ram_a` output 32: RAM word address.
- `ram_din` output 32: RAM write data.
- `ram_rw` output 1: RAM write strobe. 1 means write.
- `core_hold` output 1: holds `control_unit` off while 1.
- `done` output 1: image loaded; sticky until reset.
- `error` output 1: load failed; sticky until reset.

## Operation
- A byte transfers on a rising edge where `byte_valid && byte_ready`. No other byte is consumed.
- Stream format:
  - 4 bytes of word count N, least-significant byte first.
  - N data words, each 4 bytes, least-significant byte first.
  - With `BOOT_LOADER_CHECKSUM_EN` only: 4 checksum bytes, least-significant byte first.
- States:
  - HEADER: collect N. After the 4th byte:
    - If N > DEPTH - BASE_ADDR, go to ERROR.
    - Else if N == 0, go to CHECK or DONE.
    - Else go to DATA.
  - DATA: assemble words. After the 4th byte of word i, issue a write of that word to address BASE_ADDR + i. After word N-1, go to CHECK or DONE.
  - CHECK (macro only): collect the 32-bit checksum. If it matches, go to DONE; otherwise go to ERROR.
  - DONE: `byte_ready` = 0, `core_hold` = 0, `done` = 1. Terminal.
  - ERROR: `byte_ready` = 0, `core_hold` = 1, `error` = 1. Terminal. Words already written remain in RAM.
- Arithmetic and width rules:
  - The byte counter is 2 bits. It wraps 3 → 0 at each word boundary.
  - The word index is 32 bits and is compared against the registered N.
  - `ram_a` = BASE_ADDR + index, using 32-bit addition.
- Bytes presented in DONE or ERROR are ignored, because `byte_ready` = 0 there.
- `byte_valid` may drop mid-word. The partial word and byte counter hold their values indefinitely.

## Timing
- All outputs are registered.
- Values while `rst_n` = 0:
  - `byte_ready` = 0
  - `ram_a` = 0
  - `ram_din` = 0
  - `ram_rw` = 0
  - `core_hold` = 1
  - `done` = 0
  - `error` = 0
  - State = HEADER, all counters = 0.
- `byte_ready` rises on the first edge with `rst_n` = 1. It stays 1 through HEADER, DATA and CHECK, so the loader accepts one byte per cycle with no bubble.
- Write pulse:
  - Timing: `ram_rw` = 1 for exactly one cycle, the cycle after the edge that accepted the 4th byte of a word. `ram_a` and `ram_din` are valid in that same cycle.
  - Back-to-back words: pulses are at least 4 cycles apart, so there is never any overlap.
- Final word:
  - DONE outputs (`done` = 1, `core_hold` = 0) appear one cycle after the final write pulse. The write therefore lands before the core is released.
  - With the macro, the DONE/ERROR outputs appear one cycle after the edge that accepted the last checksum byte.
- The ERROR state on a bounds violation is entered on the edge after the 4th header byte. No write is issued.
- Reset mid-load:
  - Takes effect on the next edge. Partial state is discarded and no further writes are issued.
  - `core_hold` returns to 1 and a fresh load starts in HEADER.

## Configuration
- `BOOT_LOADER_CHECKSUM_EN` defined:
  - CHECK state and checksum register are compiled in.
  - Checksum = mod-2^32 sum of all data words.
  - A mismatch goes to ERROR; a match goes to DONE.
- Undefined:
  - No CHECK state and no checksum bytes in the stream.
  - DATA (or HEADER with N == 0) goes straight to DONE, and `error` can only come from the bounds check.

## Test plan
- Reset release, then stream `02 00 00 00 | 78 56 34 12 | EF BE AD DE`:
  - Writes 0x12345678 @0, then 0xDEADBEEF @1.
  - Each write is a one-cycle `ram_rw` pulse.
  - `done` = 1 and `core_hold` = 0 one cycle after the second pulse.
- Same image with the macro and checksum `67 15 E2 F0` (0xF0E21567):
  - `done` = 1.
  - Checksum `00 00 00 00` instead: `error` = 1, `core_hold` stays 1, both words still written.
- N = 0x2001 with BASE_ADDR = 0, DEPTH = 8192:
  - `error` = 1 the edge after the 4th header byte.
  - `ram_rw` never asserts and `byte_ready` = 0.
- Same single-word image, `byte_valid` toggling 1/0 every cycle, `byte_valid` deasserted for 5 cycles mid-word:
  - Single write of the correct word with no duplicate pulse.
  - `byte_ready` stays 1 throughout.
- Reset asserted after 6 data bytes, then a full 1-word stream `01 00 00 00 | 04 03 02 01`:
  - No write from the aborted load.
  - Word 0x01020304 written @BASE_ADDR.
  - `done` = 1.
- BASE_ADDR = 8190, N = 2:
  - Writes to 8190 and 8191, then `done` = 1.
  - With N = 3: `error` = 1 and no writes.

Source files
------------

// File: rtl/boot_loader.sv
// Serial boot-image loader: little-endian byte stream (count, words) into RAM, then core release.
// Optional trailing checksum compiled in with `define BOOT_LOADER_CHECKSUM_EN.
module boot_loader #(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] ram_a,
    output logic [31:0] ram_din,
    output logic        ram_rw,
    output logic        core_hold,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] BASE32 = 32'(BASE_ADDR);
    localparam logic [31:0] LIMIT  = 32'(DEPTH - BASE_ADDR);

`ifdef BOOT_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_HEADER, ST_DATA, ST_CHECK, ST_DONE, ST_ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_HEADER, ST_DATA, ST_LAST, ST_DONE, ST_ERROR
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [31:0] count_q, count_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] ram_a_q, ram_a_d;
    logic [31:0] ram_din_q, ram_din_d;
    logic        ram_rw_q, ram_rw_d;
    logic        ready_q, ready_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        accept;
    logic [31:0] assembled;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_HEADER;
            cnt_q     <= 2'd0;
            word_q    <= 32'd0;
            count_q   <= 32'd0;
            idx_q     <= 32'd0;
            ram_a_q   <= 32'd0;
            ram_din_q <= 32'd0;
            ram_rw_q  <= 1'b0;
            ready_q   <= 1'b0;
            hold_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_q    <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            ram_a_q   <= ram_a_d;
            ram_din_q <= ram_din_d;
            ram_rw_q  <= ram_rw_d;
            ready_q   <= ready_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            error_q   <= error_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // Next-state: bytes shift in from the top so four bytes land little-endian
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        count_d   = count_q;
        idx_d     = idx_q;
        ram_a_d   = ram_a_q;
        ram_din_d = ram_din_q;
        ram_rw_d  = 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        accept    = byte_valid && ready_q;
        assembled = {byte_data, word_q[31:8]};

        if (accept) begin
            word_d = assembled;
            cnt_d  = cnt_q + 2'd1;
            case (state_q)
                ST_HEADER: begin
                    if (cnt_q == 2'd3) begin
                        count_d = assembled;
                        if (assembled > LIMIT) begin
                            state_d = ST_ERROR;
                        end else if (assembled == 32'd0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                            state_d = ST_CHECK;
`else
                            state_d = ST_DONE;
`endif
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (cnt_q == 2'd3) begin
                        ram_rw_d  = 1'b1;
                        ram_a_d   = BASE32 + idx_q;
                        ram_din_d = assembled;
                        idx_d     = idx_q + 32'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                        csum_d    = csum_q + assembled;
                        if (idx_q == count_q - 32'd1) state_d = ST_CHECK;
`else
                        if (idx_q == count_q - 32'd1) state_d = ST_LAST;
`endif
                    end
                end
`ifdef BOOT_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (cnt_q == 2'd3) state_d = (assembled == csum_q) ? ST_DONE : ST_ERROR;
                end
`endif
                default: ;
            endcase
        end

`ifndef BOOT_LOADER_CHECKSUM_EN
        // One-cycle gap so the final write lands before the core is released
        if (state_q == ST_LAST) state_d = ST_DONE;
`endif

`ifdef BOOT_LOADER_CHECKSUM_EN
        ready_d = (state_d == ST_HEADER) || (state_d == ST_DATA) || (state_d == ST_CHECK);
`else
        ready_d = (state_d == ST_HEADER) || (state_d == ST_DATA);
`endif
        done_d  = (state_d == ST_DONE);
        hold_d  = (state_d != ST_DONE);
        error_d = (state_d == ST_ERROR);
    end

    assign byte_ready = ready_q;
    assign ram_a      = ram_a_q;
    assign ram_din    = ram_din_q;
    assign ram_rw     = ram_rw_q;
    assign core_hold  = hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: cycle table for the basic image plus directed corner sequences.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst0_n = 1'b0, rst1_n = 1'b0;
    logic [7:0]  bd0 = 8'h00, bd1 = 8'h00;
    logic        bv0 = 1'b0, bv1 = 1'b0;
    logic        rdy0, rdy1, rw0, rw1, hold0, hold1, done0, done1, err0, err1;
    logic [31:0] a0, a1, din0, din1;

    int checks = 0;
    int errors = 0;
    logic [63:0] wr0[$];
    logic [63:0] wr1[$];

    always #5 clk = ~clk;

    boot_loader #(.BASE_ADDR(0), .DEPTH(8192)) dut0 (
        .clk(clk), .rst_n(rst0_n), .byte_data(bd0), .byte_valid(bv0), .byte_ready(rdy0),
        .ram_a(a0), .ram_din(din0), .ram_rw(rw0), .core_hold(hold0), .done(done0), .error(err0)
    );

    boot_loader #(.BASE_ADDR(8190), .DEPTH(8192)) dut1 (
        .clk(clk), .rst_n(rst1_n), .byte_data(bd1), .byte_valid(bv1), .byte_ready(rdy1),
        .ram_a(a1), .ram_din(din1), .ram_rw(rw1), .core_hold(hold1), .done(done1), .error(err1)
    );

    // Capture every write pulse; a one-cycle pulse is seen on exactly one falling edge
    always @(negedge clk) begin
        if (rw0) wr0.push_back({a0, din0});
        if (rw1) wr1.push_back({a1, din1});
    end

    typedef struct packed {
        logic        rst_n;
        logic        valid;
        logic [7:0]  data;
        logic [68:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                                input logic rdy, input logic rw, input logic [31:0] a,
                                input logic [31:0] din, input logic dn, input logic er,
                                input logic hd);
        vec_t t;
        t.rst_n = r;
        t.valid = v;
        t.data  = d;
        t.exp   = {rdy, rw, a, din, dn, er, hd};
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic v, input logic [7:0] d);
        if (s == 0) begin bv0 = v; bd0 = d; end
        else        begin bv1 = v; bd1 = d; end
    endtask

    task automatic send(input int s, input logic [7:0] d);
        drive(s, 1'b1, d);
        tick();
        drive(s, 1'b0, 8'h00);
    endtask

    task automatic send_word(input int s, input logic [31:0] w);
        for (int k = 0; k < 4; k++) send(s, w[8*k +: 8]);
    endtask

    task automatic do_reset(input int s);
        drive(s, 1'b0, 8'h00);
        if (s == 0) rst0_n = 1'b0; else rst1_n = 1'b0;
        tick();
        tick();
        if (s == 0) rst0_n = 1'b1; else rst1_n = 1'b1;
        tick();
        if (s == 0) wr0.delete(); else wr1.delete();
    endtask

    vec_t vq[$];
    logic [7:0] stream[$];

    initial begin
        // Basic two-word image, cycle by cycle
        vq.push_back(mk(0, 0, 8'h00, 0, 0, 32'd0, 32'd0, 0, 0, 1));
        vq.push_back(mk(1, 0, 8'h00, 1, 0, 32'd0, 32'd0, 0, 0, 1));
        vq.push_back(mk(1, 1, 8'h02, 1, 0, 32'd0, 32'd0, 0, 0, 1));
        vq.push_back(mk(1, 1, 8'h00, 1, 0, 32'd0, 32'd0, 0, 0, 1));
        vq.push_back(mk(1, 1, 8'h00, 1, 0, 32'd0, 32'd0, 0, 0, 1));
        vq.push_back(mk(1, 1, 8'h00, 1, 0, 32'd0, 32'd0, 0, 0, 1));
        vq.push_back(mk(1, 1, 8'h78, 1, 0, 32'd0, 32'd0, 0, 0, 1));
        vq.push_back(mk(1, 1, 8'h56, 1, 0, 32'd0, 32'd0, 0, 0, 1));
        vq.push_back(mk(1, 1, 8'h34, 1, 0, 32'd0, 32'd0, 0, 0, 1));
        vq.push_back(mk(1, 1, 8'h12, 1, 1, 32'd0, 32'h12345678, 0, 0, 1));
        vq.push_back(mk(1, 1, 8'hEF, 1, 0, 32'd0, 32'h12345678, 0, 0, 1));
        vq.push_back(mk(1, 1, 8'hBE, 1, 0, 32'd0, 32'h12345678, 0, 0, 1));
        vq.push_back(mk(1, 1, 8'hAD, 1, 0, 32'd0, 32'h12345678, 0, 0, 1));
`ifdef BOOT_LOADER_CHECKSUM_EN
        vq.push_back(mk(1, 1, 8'hDE, 1, 1, 32'd1, 32'hDEADBEEF, 0, 0, 1));
        vq.push_back(mk(1, 1, 8'h67, 1, 0, 32'd1, 32'hDEADBEEF, 0, 0, 1));
        vq.push_back(mk(1, 1, 8'h15, 1, 0, 32'd1, 32'hDEADBEEF, 0, 0, 1));
        vq.push_back(mk(1, 1, 8'hE2, 1, 0, 32'd1, 32'hDEADBEEF, 0, 0, 1));
        vq.push_back(mk(1, 1, 8'hF0, 0, 0, 32'd1, 32'hDEADBEEF, 1, 0, 0));
`else
        vq.push_back(mk(1, 1, 8'hDE, 0, 1, 32'd1, 32'hDEADBEEF, 0, 0, 1));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 32'd1, 32'hDEADBEEF, 1, 0, 0));
`endif
        vq.push_back(mk(1, 1, 8'hFF, 0, 0, 32'd1, 32'hDEADBEEF, 1, 0, 0));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 32'd1, 32'hDEADBEEF, 1, 0, 0));

        #1;
        for (int i = 0; i < vq.size(); i++) begin
            rst0_n = vq[i].rst_n;
            bv0    = vq[i].valid;
            bd0    = vq[i].data;
            tick();
            chk($sformatf("table[%0d]", i), {rdy0, rw0, a0, din0, done0, err0, hold0}, vq[i].exp);
        end
        bv0 = 1'b0;
        chk("table_writes", 69'(wr0.size()), 69'd2);

        // Bounds violation: N = 0x2001 with DEPTH 8192
        do_reset(0);
        send(0, 8'h01); send(0, 8'h20); send(0, 8'h00);
        chk("bounds_pre_err", {67'd0, err0, rdy0}, 69'b01);
        send(0, 8'h00);
        chk("bounds_err", {66'd0, err0, rdy0, hold0}, 69'b101);
        for (int k = 0; k < 6; k++) send(0, 8'h55);
        chk("bounds_sticky", {66'd0, err0, done0, hold0}, 69'b101);
        chk("bounds_no_write", 69'(wr0.size()), 69'd0);

        // Single word with valid toggling and a 5-cycle stall mid-word
        do_reset(0);
        stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef BOOT_LOADER_CHECKSUM_EN
        stream.push_back(8'h78); stream.push_back(8'h56);
        stream.push_back(8'h34); stream.push_back(8'h12);
`endif
        for (int k = 0; k < stream.size(); k++) begin
            chk($sformatf("toggle_ready[%0d]", k), {68'd0, rdy0}, 69'd1);
            send(0, stream[k]);
            drive(0, 1'b0, 8'hA5);
            tick();
            if (k == 5) for (int g = 0; g < 5; g++) tick();
        end
        tick(); tick();
        chk("toggle_writes", 69'(wr0.size()), 69'd1);
        if (wr0.size() == 1) chk("toggle_word", {5'd0, wr0[0]}, {5'd0, 32'd0, 32'h12345678});
        chk("toggle_done", {66'd0, done0, err0, hold0}, 69'b100);

        // Reset after six stream bytes, then a fresh one-word load
        do_reset(0);
        send(0, 8'h01); send(0, 8'h00); send(0, 8'h00); send(0, 8'h00);
        send(0, 8'hAA); send(0, 8'hBB);
        rst0_n = 1'b0;
        tick();
        chk("abort_reset", {66'd0, rdy0, rw0, hold0}, 69'b001);
        rst0_n = 1'b1;
        tick();
        chk("abort_ready", {68'd0, rdy0}, 69'd1);
        send_word(0, 32'd1);
        send_word(0, 32'h01020304);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_word(0, 32'h01020304);
`endif
        tick(); tick();
        chk("abort_writes", 69'(wr0.size()), 69'd1);
        if (wr0.size() == 1) chk("abort_word", {5'd0, wr0[0]}, {5'd0, 32'd0, 32'h01020304});
        chk("abort_done", {66'd0, done0, err0, hold0}, 69'b100);

`ifdef BOOT_LOADER_CHECKSUM_EN
        // Bad checksum: error, core held, data still written
        do_reset(0);
        send_word(0, 32'd2);
        send_word(0, 32'h12345678);
        send_word(0, 32'hDEADBEEF);
        send_word(0, 32'h00000000);
        tick();
        chk("csum_bad", {66'd0, done0, err0, hold0}, 69'b011);
        chk("csum_bad_writes", 69'(wr0.size()), 69'd2);
`endif

        // BASE_ADDR 8190: two words fit exactly
        do_reset(1);
        send_word(1, 32'd2);
        send_word(1, 32'h11111111);
        send_word(1, 32'h22222222);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_word(1, 32'h33333333);
`endif
        tick(); tick();
        chk("edge_writes", 69'(wr1.size()), 69'd2);
        if (wr1.size() == 2) begin
            chk("edge_w0", {5'd0, wr1[0]}, {5'd0, 32'd8190, 32'h11111111});
            chk("edge_w1", {5'd0, wr1[1]}, {5'd0, 32'd8191, 32'h22222222});
        end
        chk("edge_done", {66'd0, done1, err1, hold1}, 69'b100);

        // BASE_ADDR 8190: three words overflow
        do_reset(1);
        send_word(1, 32'd3);
        chk("edge_over_err", {66'd0, err1, rdy1, hold1}, 69'b101);
        for (int k = 0; k < 4; k++) send(1, 8'h99);
        chk("edge_over_writes", 69'(wr1.size()), 69'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
